// File: rtl/niosii_debug_cmd_bridge.sv
// System-clock side of the Nios II debug slave: synchronises the virtual-JTAG
// update strobes, queues {ir, sr} commands and dispatches them as jdo plus per-IR strobes.
module niosii_debug_cmd_bridge #(
  parameter int DR_WIDTH    = 38,
  parameter int IR_WIDTH    = 2,
  parameter int ACTION_BIT  = 34,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     vs_uir,
  input  logic                     vs_udr,
  input  logic [IR_WIDTH-1:0]      ir_in,
  input  logic [DR_WIDTH-1:0]      sr,
  input  logic                     cmd_ready,
  input  logic                     clear_overflow,
  output logic                     cmd_valid,
  output logic [IR_WIDTH-1:0]      cmd_ir,
  output logic [DR_WIDTH-1:0]      cmd_data,
  output logic [DR_WIDTH-1:0]      jdo,
  output logic [2**IR_WIDTH-1:0]   take_action,
  output logic [2**IR_WIDTH-1:0]   take_no_action,
  output logic                     fifo_full,
  output logic                     overflow
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int NCH = 2**IR_WIDTH;
  localparam int EW  = IR_WIDTH + DR_WIDTH;

  logic [SYNC_STAGES-1:0] uir_sync_q, udr_sync_q;
  logic                   uir_prev_q, udr_prev_q;
  logic                   uir_rise, udr_rise;
  logic [IR_WIDTH-1:0]    ir_latch_q;
  logic [IR_WIDTH-1:0]    push_ir;

  logic [AW:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [EW-1:0]          mem_q [FIFO_DEPTH];
  logic [EW-1:0]          head;
  logic                   push, pop, drop;
  logic                   full_q, full_d;
  logic                   overflow_q, overflow_d;
  logic [DR_WIDTH-1:0]    jdo_q;
  logic [NCH-1:0]         ta_q, ta_d, tna_q, tna_d;

  // Level-to-pulse: one rise per high level, however long the tck side holds it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      uir_sync_q <= '0;
      udr_sync_q <= '0;
      uir_prev_q <= 1'b0;
      udr_prev_q <= 1'b0;
      ir_latch_q <= '0;
    end else begin
      uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
      udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
      uir_prev_q <= uir_sync_q[SYNC_STAGES-1];
      udr_prev_q <= udr_sync_q[SYNC_STAGES-1];
      if (uir_rise) ir_latch_q <= ir_in;
    end
  end

  assign uir_rise = uir_sync_q[SYNC_STAGES-1] & ~uir_prev_q;
  assign udr_rise = udr_sync_q[SYNC_STAGES-1] & ~udr_prev_q;
  assign push_ir  = uir_rise ? ir_in : ir_latch_q;

  // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
  assign cmd_valid = (wr_ptr_q != rd_ptr_q);
  assign pop       = cmd_valid & cmd_ready;
  assign push      = udr_rise & (~full_q | pop);
  assign drop      = udr_rise & full_q & ~pop;

  assign head     = mem_q[rd_ptr_q[AW-1:0]];
  assign cmd_ir   = cmd_valid ? head[EW-1:DR_WIDTH] : '0;
  assign cmd_data = cmd_valid ? head[DR_WIDTH-1:0]  : '0;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {push_ir, sr};
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ta_d       = '0;
    tna_d      = '0;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      if (cmd_data[ACTION_BIT]) ta_d[cmd_ir]  = 1'b1;
      else                      tna_d[cmd_ir] = 1'b1;
    end
    full_d     = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    overflow_d = drop | (overflow_q & ~clear_overflow);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      jdo_q      <= '0;
      ta_q       <= '0;
      tna_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      ta_q       <= ta_d;
      tna_q      <= tna_d;
      if (pop) jdo_q <= cmd_data;
    end
  end

  assign fifo_full      = full_q;
  assign overflow       = overflow_q;
  assign jdo            = jdo_q;
  assign take_action    = ta_q;
  assign take_no_action = tna_q;

endmodule

// File: tb/tb_niosii_debug_cmd_bridge.sv
// Scoreboard bench for niosii_debug_cmd_bridge: stimulus queues the expected
// dispatch, a negedge monitor checks each strobe/jdo as it appears.
module tb_niosii_debug_cmd_bridge;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        vs_uir = 1'b0, vs_udr = 1'b0;
  logic [1:0]  ir_in = '0;
  logic [37:0] sr = '0;
  logic        cmd_ready = 1'b0, clear_overflow = 1'b0;
  logic        cmd_valid;
  logic [1:0]  cmd_ir;
  logic [37:0] cmd_data, jdo;
  logic [3:0]  take_action, take_no_action;
  logic        fifo_full, overflow;

  typedef struct packed {
    logic [37:0] data;
    logic [3:0]  ta;
    logic [3:0]  tna;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  niosii_debug_cmd_bridge dut (
    .clk(clk), .reset_n(reset_n), .vs_uir(vs_uir), .vs_udr(vs_udr),
    .ir_in(ir_in), .sr(sr), .cmd_ready(cmd_ready), .clear_overflow(clear_overflow),
    .cmd_valid(cmd_valid), .cmd_ir(cmd_ir), .cmd_data(cmd_data), .jdo(jdo),
    .take_action(take_action), .take_no_action(take_no_action),
    .fifo_full(fifo_full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end else
      $display("ok   %s: %0h", name, act);
  endtask

  // Monitor: every strobe cycle must match the oldest expected dispatch.
  always @(negedge clk) begin
    if (reset_n && ((take_action | take_no_action) != 4'b0)) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_strobe: ta=%b tna=%b jdo=%0h, expected no strobe",
                 take_action, take_no_action, jdo);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        n_cmp++;
        if (take_action !== e.ta || take_no_action !== e.tna || jdo !== e.data) begin
          n_err++;
          $display("FAIL dispatch: ta=%b tna=%b jdo=%0h, expected ta=%b tna=%b jdo=%0h",
                   take_action, take_no_action, jdo, e.ta, e.tna, e.data);
        end else
          $display("ok   dispatch: ta=%b tna=%b jdo=%0h", take_action, take_no_action, jdo);
      end
    end
  end

  task automatic uir_pulse(input logic [1:0] ir);
    @(negedge clk);
    ir_in  = ir;
    vs_uir = 1'b1;
    repeat (2) @(negedge clk);
    vs_uir = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send(input logic [37:0] data, input bit accept,
                      input logic [3:0] ta, input logic [3:0] tna);
    exp_t e;
    @(negedge clk);
    sr     = data;
    vs_udr = 1'b1;
    if (accept) begin
      e.data = data; e.ta = ta; e.tna = tna;
      exp_q.push_back(e);
    end
    repeat (2) @(negedge clk);
    vs_udr = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    exp_t e;
    // Reset with toggling strobes
    repeat (3) begin
      @(negedge clk); vs_uir = 1'b1; vs_udr = 1'b1; sr = 38'h3FFFFFFFFF;
      @(negedge clk); vs_uir = 1'b0; vs_udr = 1'b0;
    end
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_jdo", jdo, 0);
    chk("rst_strobes", {take_action, take_no_action}, 0);
    chk("rst_full_ovf", {fifo_full, overflow}, 0);
    @(negedge clk); reset_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_idle", cmd_valid, 0);

    // Single command with timing check on cmd_valid
    uir_pulse(2'd2);
    @(negedge clk);
    sr = 38'h0400000005; vs_udr = 1'b1;
    e.data = 38'h0400000005; e.ta = 4'b0100; e.tna = 4'b0000;
    exp_q.push_back(e);
    @(negedge clk);
    @(negedge clk);
    vs_udr = 1'b0;
    chk("valid_before_edge3", cmd_valid, 0);
    @(negedge clk);
    chk("valid_after_edge3", cmd_valid, 1);
    chk("head_cmd_ir", cmd_ir, 2);
    chk("head_cmd_data", cmd_data, 38'h0400000005);
    cmd_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("jdo_single", jdo, 38'h0400000005);
    chk("valid_after_pop", cmd_valid, 0);

    // No-action command
    uir_pulse(2'd1);
    send(38'h0000000003, 1, 4'b0000, 4'b0010);
    // Ready while empty: jdo holds
    repeat (5) @(negedge clk);
    chk("jdo_hold_empty", jdo, 38'h0000000003);

    // Overflow: five pushes into depth 4
    cmd_ready = 1'b0;
    uir_pulse(2'd0);
    send(38'h0400000001, 1, 4'b0001, 4'b0000);
    send(38'h0000000002, 1, 4'b0000, 4'b0001);
    send(38'h0400000003, 1, 4'b0001, 4'b0000);
    chk("not_full_at_3", fifo_full, 0);
    send(38'h1000000004, 1, 4'b0000, 4'b0001);
    chk("full_at_4", fifo_full, 1);
    chk("no_ovf_at_4", overflow, 0);
    send(38'h0400000005, 0, 4'b0000, 4'b0000);
    chk("ovf_at_5", overflow, 1);
    chk("still_full_at_5", fifo_full, 1);
    cmd_ready = 1'b1;
    repeat (8) @(negedge clk);
    chk("drained_valid", cmd_valid, 0);
    chk("drained_full", fifo_full, 0);
    chk("ovf_sticky", overflow, 1);
    clear_overflow = 1'b1;
    @(negedge clk);
    clear_overflow = 1'b0;
    chk("ovf_cleared", overflow, 0);

    // Full with simultaneous push and pop, then drop racing clear_overflow
    cmd_ready = 1'b0;
    uir_pulse(2'd3);
    send(38'h0400000011, 1, 4'b1000, 4'b0000);
    send(38'h0000000012, 1, 4'b0000, 4'b1000);
    send(38'h2400000013, 1, 4'b1000, 4'b0000);
    send(38'h0000000014, 1, 4'b0000, 4'b1000);
    chk("full_before_pp", fifo_full, 1);
    @(negedge clk);
    sr = 38'h0400000015; vs_udr = 1'b1;
    e.data = 38'h0400000015; e.ta = 4'b1000; e.tna = 4'b0000;
    exp_q.push_back(e);
    @(negedge clk);
    @(negedge clk);
    vs_udr = 1'b0; cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    chk("pp_no_ovf", overflow, 0);
    chk("pp_still_full", fifo_full, 1);
    repeat (4) @(negedge clk);
    sr = 38'h00000000FF; vs_udr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vs_udr = 1'b0; clear_overflow = 1'b1;
    @(negedge clk);
    clear_overflow = 1'b0;
    chk("set_wins_ovf", overflow, 1);
    repeat (4) @(negedge clk);
    cmd_ready = 1'b1;
    repeat (8) @(negedge clk);
    chk("drain2_valid", cmd_valid, 0);
    clear_overflow = 1'b1;
    @(negedge clk);
    clear_overflow = 1'b0;

    // Same-cycle uir and udr rises take the fresh ir_in
    uir_pulse(2'd1);
    @(negedge clk);
    ir_in = 2'd3; sr = 38'h3FFFFFFFFF; vs_uir = 1'b1; vs_udr = 1'b1;
    e.data = 38'h3FFFFFFFFF; e.ta = 4'b1000; e.tna = 4'b0000;
    exp_q.push_back(e);
    repeat (2) @(negedge clk);
    vs_uir = 1'b0; vs_udr = 1'b0;
    repeat (6) @(negedge clk);

    // Asynchronous reset with two entries queued
    cmd_ready = 1'b0;
    send(38'h0400000021, 0, 4'b0000, 4'b0000);
    send(38'h0000000022, 0, 4'b0000, 4'b0000);
    chk("two_queued_valid", cmd_valid, 1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_valid", cmd_valid, 0);
    chk("async_rst_jdo", jdo, 0);
    chk("async_rst_flags", {fifo_full, overflow}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    cmd_ready = 1'b1;
    repeat (8) @(negedge clk);
    chk("post_async_rst_idle", cmd_valid, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
